// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the memory-backed slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BEAT_CNT_W = 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word-addressed RAM: one byte-enabled write port, one asynchronous read port.
module axi_slave_mem_ram #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // One narrow array per byte lane keeps the byte enables as plain write enables.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) begin
        lane_mem[waddr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/axi_full_slave_mem.sv
// AXI4 full slave backed by on-chip memory; independent write and read FSMs,
// one outstanding transaction each, INCR/FIXED bursts up to 256 beats.
module axi_full_slave_mem
  import axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_MEM_DEPTH_LOG2 = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDW      = C_S_AXI_ID_WIDTH;
  localparam int IDX_W    = C_S_MEM_DEPTH_LOG2;
  localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0]      IDX_ONE = IDX_W'(1);
  localparam logic [BEAT_CNT_W-1:0] CNT_ONE = BEAT_CNT_W'(1);

  // WRAP and the reserved encoding both step like INCR.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [1:0]       burst);
    return (burst == BURST_FIXED) ? idx : idx + IDX_ONE;
  endfunction

  w_state_t              w_state_reg;
  logic [IDW-1:0]        w_id_reg;
  logic [IDX_W-1:0]      w_idx_reg;
  logic [BEAT_CNT_W-1:0] w_len_reg;
  logic [BEAT_CNT_W-1:0] w_cnt_reg;
  logic [1:0]            w_burst_reg;
  logic                  w_err_reg;
  logic                  awready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [IDW-1:0]        bid_reg;

  r_state_t              r_state_reg;
  logic [IDX_W-1:0]      r_idx_reg;
  logic [BEAT_CNT_W-1:0] r_len_reg;
  logic [BEAT_CNT_W-1:0] r_cnt_reg;
  logic [1:0]            r_burst_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic                  rlast_reg;
  logic [1:0]            rresp_reg;
  logic [IDW-1:0]        rid_reg;

  logic                          aw_fire;
  logic                          w_fire;
  logic                          w_final;
  logic                          w_err_next;
  logic                          ar_fire;
  logic                          r_fire;
  logic [BEAT_CNT_W-1:0]         r_cnt_inc;
  logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;
  logic                          unused_inputs;

  assign aw_fire    = S_AXI_AWVALID && awready_reg;
  assign w_fire     = S_AXI_WVALID && wready_reg;
  assign w_final    = (w_cnt_reg == w_len_reg);
  // WLAST must coincide exactly with the beat where the counter reaches len.
  assign w_err_next = w_err_reg || (S_AXI_WLAST != w_final);
  assign ar_fire    = S_AXI_ARVALID && arready_reg;
  assign r_fire     = S_AXI_RREADY && rvalid_reg;
  assign r_cnt_inc  = r_cnt_reg + CNT_ONE;

  assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWSIZE, S_AXI_ARSIZE};

  axi_slave_mem_ram #(
    .DATA_W     (C_S_AXI_DATA_WIDTH),
    .DEPTH_LOG2 (C_S_MEM_DEPTH_LOG2)
  ) u_ram (
    .clk   (S_AXI_ACLK),
    .we    (w_fire),
    .waddr (w_idx_reg),
    .wdata (S_AXI_WDATA),
    .wstrb (S_AXI_WSTRB),
    .raddr (r_idx_reg),
    .rdata (ram_rdata)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_reg <= W_IDLE;
      w_id_reg    <= '0;
      w_idx_reg   <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_burst_reg <= BURST_INCR;
      w_err_reg   <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      bid_reg     <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          if (aw_fire) begin
            w_id_reg    <= S_AXI_AWID;
            w_idx_reg   <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
            w_len_reg   <= S_AXI_AWLEN;
            w_cnt_reg   <= '0;
            w_burst_reg <= S_AXI_AWBURST;
            w_err_reg   <= (S_AXI_AWBURST == BURST_RSVD);
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx_reg <= next_idx(w_idx_reg, w_burst_reg);
            w_cnt_reg <= w_cnt_reg + CNT_ONE;
            w_err_reg <= w_err_next;
            if (w_final) begin
              wready_reg  <= 1'b0;
              bvalid_reg  <= 1'b1;
              bresp_reg   <= w_err_next ? RESP_SLVERR : RESP_OKAY;
              bid_reg     <= w_id_reg;
              w_state_reg <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_reg <= R_IDLE;
      r_idx_reg   <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_burst_reg <= BURST_INCR;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rid_reg     <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (ar_fire) begin
            r_idx_reg   <= S_AXI_ARADDR[ADDR_LSB +: IDX_W];
            r_len_reg   <= S_AXI_ARLEN;
            r_cnt_reg   <= '0;
            r_burst_reg <= S_AXI_ARBURST;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rlast_reg   <= (S_AXI_ARLEN == '0);
            rresp_reg   <= (S_AXI_ARBURST == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
            rid_reg     <= S_AXI_ARID;
            r_state_reg <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (rlast_reg) begin
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              rresp_reg   <= RESP_OKAY;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              r_idx_reg <= next_idx(r_idx_reg, r_burst_reg);
              r_cnt_reg <= r_cnt_inc;
              rlast_reg <= (r_cnt_inc == r_len_reg);
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_BID     = bid_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RLAST   = rlast_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RID     = rid_reg;
  assign S_AXI_RDATA   = rvalid_reg ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Directed self-checking bench for axi_full_slave_mem.
module tb_axi_full_slave_mem;
  import axi_pkg::*;

  localparam int IDW = 1;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IDW-1:0]  awid = '0;
  logic [AW-1:0]   awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = 3'd3;
  logic [1:0]      awburst = BURST_INCR;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wlast = 1'b0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [IDW-1:0]  arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = 3'd3;
  logic [1:0]      arburst = BURST_INCR;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] wbuf [256];
  logic [DW-1:0] rbuf [256];
  logic          rlast_buf [256];

  always #5 clk = ~clk;

  axi_full_slave_mem #(
    .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW), .C_S_MEM_DEPTH_LOG2(8)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [IDW-1:0] id);
    int n = 0;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    checks++;
    if (awready !== 1'b1) begin
      failures++;
      $display("FAIL aw_handshake awready=%0b required=1 after %0d cycles", awready, n);
    end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [IDW-1:0] id);
    int n = 0;
    araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    checks++;
    if (arready !== 1'b1) begin
      failures++;
      $display("FAIL ar_handshake arready=%0b required=1 after %0d cycles", arready, n);
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 20) begin tick(); n++; end
    checks++;
    if (wready !== 1'b1) begin
      failures++;
      $display("FAIL w_handshake wready=%0b required=1 after %0d cycles", wready, n);
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Sends wbuf[0..len]; WLAST is driven only on beat index wlast_beat (-1: never).
  task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [IDW-1:0] id,
                             input int wlast_beat, input logic [DW/8-1:0] strb,
                             input int b_delay, output logic [1:0] resp,
                             output logic [IDW-1:0] bid_o);
    int n = 0;
    aw_send(addr, len, burst, id);
    for (int i = 0; i <= int'(len); i++) w_beat(wbuf[i], strb, i == wlast_beat);
    for (int k = 0; k < b_delay; k++) begin
      checks++;
      if (bvalid !== 1'b1) begin
        failures++;
        $display("FAIL bvalid_hold stall=%0d bvalid=%0b required=1", k, bvalid);
      end
      tick();
    end
    bready = 1'b1;
    while (!bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (bvalid !== 1'b1) begin
      failures++;
      $display("FAIL b_handshake bvalid=%0b required=1 after %0d cycles", bvalid, n);
    end
    resp = bresp; bid_o = bid;
    tick();
    bready = 1'b0;
  endtask

  // Collects beats into rbuf/rlast_buf; with stall set, RREADY drops on some cycles.
  task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [IDW-1:0] id,
                            input bit stall, output logic [1:0] resp,
                            output logic [IDW-1:0] rid_o);
    int i = 0;
    int n = 0;
    bit held = 1'b0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    ar_send(addr, len, burst, id);
    resp = 2'bxx; rid_o = 'x;
    while (i <= int'(len) && n < 3000) begin
      rready = stall ? ((n % 3) != 1 && $urandom_range(0, 3) != 0) : 1'b1;
      if (held) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== hd || rlast !== hl) begin
          failures++;
          $display("FAIL r_stall_hold beat=%0d rvalid=%0b rdata=%h required=%h rlast=%0b required=%0b",
                   i, rvalid, rdata, hd, rlast, hl);
        end
      end
      held = 1'b0;
      if (rvalid) begin
        if (rready) begin
          rbuf[i] = rdata; rlast_buf[i] = rlast;
          if (i == 0) begin resp = rresp; rid_o = rid; end
          i++;
        end else begin
          held = 1'b1; hd = rdata; hl = rlast;
        end
      end
      tick();
      n++;
    end
    rready = 1'b0;
    checks++;
    if (i <= int'(len)) begin
      failures++;
      $display("FAIL r_beats got=%0d required=%0d", i, int'(len) + 1);
    end
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++;
      $display("FAIL r_return_idle rvalid=%0b arready=%0b required rvalid=0 arready=1", rvalid, arready);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs awready=%0b wready=%0b bvalid=%0b arready=%0b rvalid=%0b rdata=%h required all 0",
               awready, wready, bvalid, arready, rvalid, rdata);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release awready=%0b arready=%0b required 1 1", awready, arready);
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    logic [IDW-1:0] id_o;
    for (int i = 0; i < 17; i++) wbuf[i] = 64'(i + 1);
    write_burst(32'h4000_0000, 8'd16, BURST_INCR, 1'b1, 16, 8'hFF, 0, resp, id_o);
    checks++;
    if (resp !== RESP_OKAY || id_o !== 1'b1) begin
      failures++;
      $display("FAIL incr_bresp bresp=%b bid=%0b required 00 1", resp, id_o);
    end
    read_burst(32'h4000_0000, 8'd16, BURST_INCR, 1'b1, 1'b0, resp, id_o);
    checks++;
    if (resp !== RESP_OKAY || id_o !== 1'b1) begin
      failures++;
      $display("FAIL incr_rresp rresp=%b rid=%0b required 00 1", resp, id_o);
    end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (rbuf[i] !== 64'(i + 1) || rlast_buf[i] !== (i == 16)) begin
        failures++;
        $display("FAIL incr_beat%0d rdata=%h rlast=%0b required %h %0b", i, rbuf[i], rlast_buf[i], 64'(i + 1), i == 16);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [IDW-1:0] id_o;
    wbuf[0] = '1;
    write_burst(32'h0000_0640, 8'd0, BURST_INCR, 1'b0, 0, 8'hFF, 0, resp, id_o);
    wbuf[0] = '0;
    write_burst(32'h0000_0640, 8'd0, BURST_INCR, 1'b0, 0, 8'h0F, 0, resp, id_o);
    read_burst(32'h0000_0640, 8'd0, BURST_INCR, 1'b0, 1'b0, resp, id_o);
    checks++;
    if (rbuf[0] !== 64'hFFFF_FFFF_0000_0000) begin
      failures++;
      $display("FAIL strobe_word rdata=%h required ffffffff00000000", rbuf[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp;
    logic [IDW-1:0] id_o;
    read_burst(32'h4000_0000, 8'd16, BURST_INCR, 1'b0, 1'b1, resp, id_o);
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (rbuf[i] !== 64'(i + 1) || rlast_buf[i] !== (i == 16)) begin
        failures++;
        $display("FAIL stall_beat%0d rdata=%h rlast=%0b required %h %0b", i, rbuf[i], rlast_buf[i], 64'(i + 1), i == 16);
      end
    end
    wbuf[0] = 64'hDEAD_BEEF_0000_0064;
    write_burst(32'h0000_0320, 8'd0, BURST_INCR, 1'b1, 0, 8'hFF, 3, resp, id_o);
    checks++;
    if (resp !== RESP_OKAY || id_o !== 1'b1) begin
      failures++;
      $display("FAIL bstall_bresp bresp=%b bid=%0b required 00 1", resp, id_o);
    end
  endtask

  task automatic test_wlast_err();
    logic [1:0] resp;
    logic [IDW-1:0] id_o;
    for (int i = 0; i < 17; i++) wbuf[i] = 64'h100 + 64'(i);
    write_burst(32'h0000_0100, 8'd16, BURST_INCR, 1'b0, 4, 8'hFF, 0, resp, id_o);
    checks++;
    if (resp !== RESP_SLVERR) begin
      failures++;
      $display("FAIL early_wlast_bresp bresp=%b required 10", resp);
    end
    read_burst(32'h0000_0100, 8'd16, BURST_INCR, 1'b0, 1'b0, resp, id_o);
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (rbuf[i] !== 64'h100 + 64'(i)) begin
        failures++;
        $display("FAIL early_wlast_beat%0d rdata=%h required %h", i, rbuf[i], 64'h100 + 64'(i));
      end
    end
    write_burst(32'h0000_0280, 8'd1, BURST_INCR, 1'b0, -1, 8'hFF, 0, resp, id_o);
    checks++;
    if (resp !== RESP_SLVERR) begin
      failures++;
      $display("FAIL missing_wlast_bresp bresp=%b required 10", resp);
    end
    write_burst(32'h0000_0300, 8'd0, BURST_RSVD, 1'b0, 0, 8'hFF, 0, resp, id_o);
    checks++;
    if (resp !== RESP_SLVERR) begin
      failures++;
      $display("FAIL rsvd_bresp bresp=%b required 10", resp);
    end
    read_burst(32'h0000_0300, 8'd0, BURST_RSVD, 1'b0, 1'b0, resp, id_o);
    checks++;
    if (resp !== RESP_SLVERR) begin
      failures++;
      $display("FAIL rsvd_rresp rresp=%b required 10", resp);
    end
  endtask

  task automatic test_wrap_fixed();
    logic [1:0] resp;
    logic [IDW-1:0] id_o;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
    write_burst(32'h4000_07F0, 8'd3, BURST_INCR, 1'b0, 3, 8'hFF, 0, resp, id_o);
    read_burst(32'h0000_07F0, 8'd1, BURST_INCR, 1'b0, 1'b0, resp, id_o);
    checks++;
    if (rbuf[0] !== 64'hA0 || rbuf[1] !== 64'hA1) begin
      failures++;
      $display("FAIL wrap_top rdata=%h,%h required a0,a1", rbuf[0], rbuf[1]);
    end
    read_burst(32'h0000_0000, 8'd1, BURST_INCR, 1'b0, 1'b0, resp, id_o);
    checks++;
    if (rbuf[0] !== 64'hA2 || rbuf[1] !== 64'hA3) begin
      failures++;
      $display("FAIL wrap_bottom rdata=%h,%h required a2,a3", rbuf[0], rbuf[1]);
    end
    wbuf[0] = 64'h0A; wbuf[1] = 64'h0B; wbuf[2] = 64'h0C; wbuf[3] = 64'h0D;
    write_burst(32'h0000_0050, 8'd3, BURST_FIXED, 1'b1, 3, 8'hFF, 0, resp, id_o);
    checks++;
    if (resp !== RESP_OKAY) begin
      failures++;
      $display("FAIL fixed_bresp bresp=%b required 00", resp);
    end
    read_burst(32'h0000_0050, 8'd2, BURST_FIXED, 1'b0, 1'b0, resp, id_o);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rbuf[i] !== 64'h0D) begin
        failures++;
        $display("FAIL fixed_beat%0d rdata=%h required d", i, rbuf[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [IDW-1:0] id_o;
    aw_send(32'h0000_01E0, 8'd7, BURST_INCR, 1'b0);
    for (int i = 0; i < 4; i++) w_beat(64'h600 + 64'(i), 8'hFF, 1'b0);
    rst = 1'b1;
    tick();
    checks++;
    if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid, rdata} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs awready=%0b wready=%0b bvalid=%0b arready=%0b required all 0",
               awready, wready, bvalid, arready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release awready=%0b arready=%0b wready=%0b required 1 1 0", awready, arready, wready);
    end
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h700 + 64'(i);
    write_burst(32'h0000_0230, 8'd3, BURST_INCR, 1'b1, 3, 8'hFF, 0, resp, id_o);
    checks++;
    if (resp !== RESP_OKAY || id_o !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_bresp bresp=%b bid=%0b required 00 1", resp, id_o);
    end
    read_burst(32'h0000_0230, 8'd3, BURST_INCR, 1'b0, 1'b0, resp, id_o);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 64'h700 + 64'(i)) begin
        failures++;
        $display("FAIL after_reset_beat%0d rdata=%h required %h", i, rbuf[i], 64'h700 + 64'(i));
      end
    end
    read_burst(32'h0000_01E0, 8'd3, BURST_INCR, 1'b0, 1'b0, resp, id_o);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 64'h600 + 64'(i)) begin
        failures++;
        $display("FAIL partial_beat%0d rdata=%h required %h", i, rbuf[i], 64'h600 + 64'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    $display("test_reset done checks=%0d", checks);
    test_incr();
    $display("test_incr done checks=%0d", checks);
    test_strobe();
    $display("test_strobe done checks=%0d", checks);
    test_backpressure();
    $display("test_backpressure done checks=%0d", checks);
    test_wlast_err();
    $display("test_wlast_err done checks=%0d", checks);
    test_wrap_fixed();
    $display("test_wrap_fixed done checks=%0d", checks);
    test_reset_mid();
    $display("test_reset_mid done checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
